// File: rtl/proc_pkg.sv
// Shared opcode/step encodings and instruction field positions for param_proc_core.
package proc_pkg;

    typedef enum logic [2:0] {
        OP_MV  = 3'd0,
        OP_MVI = 3'd1,
        OP_ADD = 3'd2,
        OP_SUB = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_NOP = 3'd7
    } op_e;

    typedef enum logic [1:0] {T0, T1, T2, T3} step_e;

    // Instruction layout is {opcode[2:0], rx, ry}, ry in the low bits.
    localparam int IR_RY_LSB = 0;

    function automatic int ir_rx_lsb(input int idx_w);
        return idx_w;
    endfunction

    function automatic int ir_op_lsb(input int idx_w);
        return 2 * idx_w;
    endfunction

    function automatic logic is_alu(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: A op bus with carry (add) or borrow (sub); logic ops clear carry.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op_e'(op))
            OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/param_proc_core.sv
// Multi-cycle datapath core: register file, shared bus, A/G staging and T0..T3 step FSM.
// Define PROC_FLAGS_EN to build zero/carry flag registers loaded on every G load.
module param_proc_core
    import proc_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int NUM_REGS  = 8,
    localparam int REG_IDX_W = $clog2(NUM_REGS),
    localparam int IR_W      = 3 + 2 * REG_IDX_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [IR_W-1:0]   instr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] bus,
    output logic              busy,
    output logic              done,
    output logic              z_flag,
    output logic              c_flag
);

    localparam int OP_LSB = ir_op_lsb(REG_IDX_W);
    localparam int RX_LSB = ir_rx_lsb(REG_IDX_W);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DATA_W-1:0]               a_q, a_d, g_q, g_d;
    logic [IR_W-1:0]                 ir_q, ir_d;
    step_e                           step_q, step_d;

    op_e                  op;
    logic [REG_IDX_W-1:0] rx, ry;
    logic [DATA_W-1:0]    alu_res;
    logic                 alu_carry;

    assign op = op_e'(ir_q[OP_LSB +: 3]);
    assign rx = ir_q[RX_LSB +: REG_IDX_W];
    assign ry = ir_q[IR_RY_LSB +: REG_IDX_W];

    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (ir_q[OP_LSB +: 3]),
        .a      (a_q),
        .b      (bus),
        .result (alu_res),
        .carry  (alu_carry)
    );

    // Single bus driver: the step/opcode decode selects exactly one source.
    always_comb begin
        bus = '0;
        case (step_q)
            T1: begin
                case (op)
                    OP_MV:   bus = regs_q[ry];
                    OP_MVI:  bus = data_in;
                    OP_NOP:  bus = '0;
                    default: bus = regs_q[rx];
                endcase
            end
            T2:      bus = regs_q[ry];
            T3:      bus = g_q;
            default: bus = '0;
        endcase
    end

    assign busy = (step_q != T0);
    assign done = ((step_q == T1) && !is_alu(op)) || (step_q == T3);

    always_comb begin
        regs_d = regs_q;
        a_d    = a_q;
        g_d    = g_q;
        ir_d   = ir_q;
        step_d = step_q;
        case (step_q)
            T0: begin
                if (start) begin
                    ir_d   = instr_in;
                    step_d = T1;
                end
            end
            T1: begin
                if (is_alu(op)) begin
                    a_d    = bus;
                    step_d = T2;
                end else begin
                    if (op != OP_NOP) regs_d[rx] = bus;
                    step_d = T0;
                end
            end
            T2: begin
                g_d    = alu_res;
                step_d = T3;
            end
            T3: begin
                regs_d[rx] = bus;
                step_d     = T0;
            end
            default: step_d = T0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '0;
            a_q    <= '0;
            g_q    <= '0;
            ir_q   <= '0;
            step_q <= T0;
        end else begin
            regs_q <= regs_d;
            a_q    <= a_d;
            g_q    <= g_d;
            ir_q   <= ir_d;
            step_q <= step_d;
        end
    end

`ifdef PROC_FLAGS_EN
    logic z_q, z_d, c_q, c_d;

    // T2 is only reached by ALU ops, so it marks every G load.
    always_comb begin
        z_d = z_q;
        c_d = c_q;
        if (step_q == T2) begin
            z_d = (alu_res == '0);
            c_d = alu_carry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            z_q <= 1'b0;
            c_q <= 1'b0;
        end else begin
            z_q <= z_d;
            c_q <= c_d;
        end
    end

    assign z_flag = z_q;
    assign c_flag = c_q;
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
    assign z_flag       = 1'b0;
    assign c_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_param_proc_core.sv
// Bench for param_proc_core (DATA_W=8, NUM_REGS=8): directed table, hand sequences, random vs model.
module tb_param_proc_core;

`ifdef PROC_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       start;
    logic [8:0] instr_in;
    logic [7:0] data_in;
    logic [7:0] bus;
    logic       busy;
    logic       done;
    logic       z_flag;
    logic       c_flag;

    int n_tot  = 0;
    int n_pass = 0;

    logic [7:0] mregs [8];
    bit         mz, mc;

    param_proc_core #(.DATA_W(8), .NUM_REGS(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .instr_in (instr_in),
        .data_in  (data_in),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .z_flag   (z_flag),
        .c_flag   (c_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mz = 1'b0;
        mc = 1'b0;
    endtask

    // Reference: expected bus per busy cycle from the instruction semantics.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                             input logic [7:0] d, output logic [7:0] done_bus);
        logic [7:0] exp_b[$];
        logic [7:0] a, b, r;
        bit         c;
        int         t;
        a = mregs[rx];
        b = mregs[ry];
        r = 8'h00;
        c = 1'b0;
        done_bus = 8'h00;
        case (op)
            3'd0: exp_b.push_back(b);
            3'd1: exp_b.push_back(d);
            3'd7: exp_b.push_back(8'h00);
            default: begin
                case (op)
                    3'd2: begin t = int'(a) + int'(b); c = (t > 255); r = t[7:0]; end
                    3'd3: begin t = int'(a) - int'(b); c = (t < 0);   r = t[7:0]; end
                    3'd4: r = a & b;
                    3'd5: r = a | b;
                    default: r = a ^ b;
                endcase
                exp_b.push_back(a);
                exp_b.push_back(b);
                exp_b.push_back(r);
            end
        endcase
        @(negedge clock);
        start    = 1'b1;
        instr_in = {op, rx, ry};
        data_in  = d;
        foreach (exp_b[k]) begin
            @(negedge clock);
            if (k == 0) begin
                start    = 1'b0;
                instr_in = 9'($urandom);
            end
            chk("busy", busy, 1);
            chk("done", done, 16'(k == exp_b.size() - 1));
            chk("bus", bus, exp_b[k]);
            done_bus = bus;
        end
        if (op == 3'd0 || op == 3'd1) mregs[rx] = exp_b[0];
        else if (op != 3'd7) begin
            mregs[rx] = r;
            if (FLAGS) begin
                mz = (r == 8'h00);
                mc = c;
            end
        end
        @(negedge clock);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_bus", bus, 0);
        chk("z_flag", z_flag, mz);
        chk("c_flag", c_flag, mc);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [7:0] d;
        logic [7:0] exp_bus;
        bit         ez;
        bit         ec;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [7:0] db;

        tbl[0]  = '{3'd1, 3'd0, 3'd0, 8'h5A, 8'h5A, 0, 0};
        tbl[1]  = '{3'd0, 3'd3, 3'd0, 8'h00, 8'h5A, 0, 0};
        tbl[2]  = '{3'd0, 3'd1, 3'd3, 8'h00, 8'h5A, 0, 0};
        tbl[3]  = '{3'd1, 3'd1, 3'd5, 8'hFF, 8'hFF, 0, 0};
        tbl[4]  = '{3'd1, 3'd2, 3'd0, 8'h01, 8'h01, 0, 0};
        tbl[5]  = '{3'd2, 3'd1, 3'd2, 8'h00, 8'h00, 1, 1};
        tbl[6]  = '{3'd1, 3'd4, 3'd0, 8'h00, 8'h00, 1, 1};
        tbl[7]  = '{3'd1, 3'd5, 3'd0, 8'h01, 8'h01, 1, 1};
        tbl[8]  = '{3'd3, 3'd4, 3'd5, 8'h00, 8'hFF, 0, 1};
        tbl[9]  = '{3'd6, 3'd4, 3'd4, 8'h00, 8'h00, 1, 0};
        tbl[10] = '{3'd1, 3'd6, 3'd0, 8'h41, 8'h41, 1, 0};
        tbl[11] = '{3'd2, 3'd6, 3'd6, 8'h00, 8'h82, 0, 0};
        tbl[12] = '{3'd4, 3'd6, 3'd0, 8'h00, 8'h02, 0, 0};
        tbl[13] = '{3'd5, 3'd6, 3'd0, 8'h00, 8'h5A, 0, 0};
        tbl[14] = '{3'd7, 3'd2, 3'd3, 8'h00, 8'h00, 0, 0};
        tbl[15] = '{3'd0, 3'd7, 3'd7, 8'h00, 8'h00, 0, 0};
        tbl[16] = '{3'd3, 3'd2, 3'd2, 8'h00, 8'h00, 1, 0};

        // Reset held two cycles with start asserted: nothing may be accepted.
        model_reset();
        reset    = 1'b1;
        start    = 1'b1;
        instr_in = {3'd1, 3'd2, 3'd0};
        data_in  = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("rst_bus", bus, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 8; i++) run_instr(3'd0, 3'(i), 3'(i), 8'h00, db);

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].rx, tbl[i].ry, tbl[i].d, db);
            chk($sformatf("tbl%0d_bus", i), db, tbl[i].exp_bus);
            chk($sformatf("tbl%0d_z", i), z_flag, FLAGS ? tbl[i].ez : 1'b0);
            chk($sformatf("tbl%0d_c", i), c_flag, FLAGS ? tbl[i].ec : 1'b0);
        end

        // Back-to-back adds with start held high; instr_in wiggles while busy.
        run_instr(3'd1, 3'd1, 3'd0, 8'h03, db);
        run_instr(3'd1, 3'd2, 3'd0, 8'h01, db);
        @(negedge clock);
        start    = 1'b1;
        instr_in = {3'd2, 3'd1, 3'd2};
        @(negedge clock);
        chk("b2b_t1_bus", bus, 8'h03);
        instr_in = {3'd1, 3'd1, 3'd0};
        @(negedge clock);
        chk("b2b_t2_bus", bus, 8'h01);
        chk("b2b_t2_done", done, 0);
        @(negedge clock);
        chk("b2b_t3_bus", bus, 8'h04);
        chk("b2b_t3_done", done, 1);
        instr_in = {3'd2, 3'd1, 3'd2};
        @(negedge clock);
        chk("b2b_gap_busy", busy, 0);
        chk("b2b_gap_bus", bus, 8'h00);
        @(negedge clock);
        chk("b2b_2nd_busy", busy, 1);
        chk("b2b_2nd_bus", bus, 8'h04);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("b2b_2nd_res", bus, 8'h05);
        chk("b2b_2nd_done", done, 1);
        mregs[1] = 8'h05;
        if (FLAGS) begin
            mz = 1'b0;
            mc = 1'b0;
        end
        @(negedge clock);
        chk("b2b_z", z_flag, mz);
        chk("b2b_c", c_flag, mc);
        run_instr(3'd0, 3'd1, 3'd1, 8'h00, db);

        // Reset asserted in T2 of an add aborts it and clears everything.
        @(negedge clock);
        start    = 1'b1;
        instr_in = {3'd2, 3'd1, 3'd2};
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("abort_t2_bus", bus, 8'h01);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_bus", bus, 0);
        chk("abort_done", done, 0);
        chk("abort_z", z_flag, 0);
        chk("abort_c", c_flag, 0);
        model_reset();
        for (int i = 0; i < 8; i++) run_instr(3'd0, 3'(i), 3'(i), 8'h00, db);

        // Random instruction stream against the model.
        for (int i = 0; i < 200; i++)
            run_instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 8'($urandom), db);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/param_proc_core.md
Name: param_proc_core

Overview:
- Next-generation multi-cycle datapath processor core: register file, shared internal bus, ALU with A/G staging registers, and a step-counter control FSM.
- Generalised in data width and register count. Adds an explicit start/busy/done instruction handshake and XOR/OR/AND operations.
- Sits between an instruction/immediate source and any consumer that monitors the bus.

Parameters:
- DATA_W, 8, width of registers, bus, data_in and ALU.
- NUM_REGS, 8, number of general registers R0..R(NUM_REGS-1); must be a power of two, 2..16.
- REG_IDX_W (localparam), clog2(NUM_REGS), width of a register index.
- IR_W (localparam), 3+2*REG_IDX_W, instruction width; layout is {opcode[2:0], rx, ry}.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to execute instr_in; sampled only in step T0.
- instr_in  in  IR_W  instruction word, latched into IR when start is accepted.
- data_in  in  DATA_W  immediate operand for mvi; sampled in T1.
- bus  out  DATA_W  internal bus value.
- busy  out  1  high in steps T1..T3.
- done  out  1  high during the final step of an instruction.
- z_flag  out  1  zero flag (see Optional Feature).
- c_flag  out  1  carry/borrow flag (see Optional Feature).

Behaviour:
- Reset (sync, active-high): all Rn, A, G and IR cleared to 0; step = T0; flags = 0. Outputs after reset: bus = 0, busy = 0, done = 0. Reset mid-instruction aborts it; no register write occurs in that cycle.
- Step FSM states: T0 (idle), T1, T2, T3.
  - T0 -> T1 when start = 1 (IR <= instr_in).
  - After the final step of an instruction, the FSM returns to T0.
- start is ignored in T1..T3, including the done cycle. The earliest next accept is the cycle after done.
- Opcodes:
  - 000 mv
  - 001 mvi
  - 010 add
  - 011 sub
  - 100 and
  - 101 or
  - 110 xor
  - 111 nop
- mv Rx,Ry: T1: bus = Ry, Rx <= bus, done. Latency 1 cycle after accept.
- mvi Rx: T1: bus = data_in, Rx <= bus, done. The ry field is ignored.
- ALU ops:
  - T1: bus = Rx, A <= bus.
  - T2: bus = Ry, G <= A op bus.
  - T3: bus = G, Rx <= bus, done.
  - Latency 3 cycles.
- nop: T1 done; bus = 0; no writes.
- bus = 0 in T0.
- bus, busy and done are combinational decodes of step and IR; no internal bus contention is possible.
- Arithmetic is modulo 2^DATA_W (wrap-around): 0xFF+0x01 = 0x00; 0x00-0x01 = 0xFF.
- Rx == Ry is legal; A is staged first, so add R1,R1 doubles R1.
- Write to Rx takes effect at the edge ending the done cycle and is visible on the bus from the next instruction onward.

Optional Feature:
- Macro: PROC_FLAGS_EN.
- Defined:
  - On every G load (T2 of an ALU op), z_flag <= (result == 0).
  - add: c_flag <= carry-out.
  - sub: c_flag <= borrow (A < bus, unsigned).
  - and/or/xor: c_flag <= 0.
  - Flags hold across mv/mvi/nop and clear on reset.
- Undefined: z_flag and c_flag are tied to 0; no flag registers are built.

Decomposition:
- Package proc_pkg: opcode constants/enum (OP_MV..OP_NOP), step enum (T0..T3), and IR field position helpers.
- One sub-module, proc_alu: combinational A op bus -> result plus carry/borrow, parametrised by DATA_W.
- Register file, FSM and bus mux remain in param_proc_core.

Test Plan:
- Reset held 2 cycles while start = 1 -> bus = 0, busy = 0, done = 0, all regs 0; no instruction accepted.
- mvi R0 with data_in = 0x5A, then mv R3,R0 -> done one cycle after each accept; R3 = 0x5A on the bus during the next mv R1,R3.
- R1 = 0xFF, R2 = 0x01, add R1,R2 -> bus shows 0xFF (T1), 0x01 (T2), 0x00 (T3); done in T3; R1 = 0x00; with PROC_FLAGS_EN, z = 1 and c = 1.
- R4 = 0x00, R5 = 0x01, sub R4,R5 -> R4 = 0xFF; with flags, z = 0 and c = 1. Then xor R4,R4 -> R4 = 0x00, z = 1, c = 0.
- start held high continuously over back-to-back adds -> second instruction accepted exactly the cycle after done; instr_in changes during busy have no effect.
- Assert reset in T2 of an add -> next cycle step = T0, all regs 0, no write to Rx; NUM_REGS = 16, DATA_W = 16 build passes the same sequence scaled.
